// File: rtl/multibyte_add_sequencer.sv
// Byte-serial W-bit adder that drives an external 8-bit adder one byte per cycle.
// Optional: define MULTIBYTE_ADD_SEQ_OVF_EN to add the signed overflow output ovf.
module multibyte_add_sequencer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] op_a,
  input  logic [8*NUM_BYTES-1:0] op_b,
  input  logic                   op_cin,
  output logic [7:0]             add_a,
  output logic [7:0]             add_b,
  output logic                   add_cin,
  input  logic [7:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   cout
`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               cin_q;
  logic [IDX_W-1:0]   idx;
  logic               carry_q;
  logic [W-1:0]       result_q;
  logic               cout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      idx      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            cin_q <= op_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          // Each edge retires one byte; the carry ripples only via carry_q.
          result_q[8*idx +: 8] <= add_sum;
          carry_q              <= add_cout;
          if (idx == LAST_IDX) begin
            cout_q <= add_cout;
            idx    <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULTIBYTE_ADD_SEQ_OVF_EN
  logic ovf_q;

  // Overflow is decided on the last byte's edge from the operand and sum sign bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && idx == LAST_IDX) begin
      ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = 8'h00;
    add_b      = 8'h00;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a   = a_q[8*idx +: 8];
        add_b   = b_q[8*idx +: 8];
        add_cin = (idx == '0) ? cin_q : carry_q;
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign result = result_q;
  assign cout   = cout_q;

endmodule
